switch_debounce_toggle: RTL

// Input-side conditioning for the board's push-button switches. The gate and LED

---
 rtl/switch_debounce_toggle.sv | 82 ++++++++
 1 files changed

// File: rtl/switch_debounce_toggle.sv
// Per-switch input conditioning: synchroniser, debounce counter, stable level,
// registered rise/fall pulses and an LED toggle register that flips on every release.
module switch_debounce_toggle #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Sw_Level,
    output logic [NUM_SW-1:0] o_Sw_Rise,
    output logic [NUM_SW-1:0] o_Sw_Fall,
    output logic [NUM_SW-1:0] o_LED_Toggle
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SW-1:0] sync;

    logic [CNT_W-1:0]  count_q [NUM_SW];
    logic [CNT_W-1:0]  count_d [NUM_SW];
    logic [NUM_SW-1:0] level_d;
    logic [NUM_SW-1:0] rise_d;
    logic [NUM_SW-1:0] fall_d;
    logic [NUM_SW-1:0] toggle_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // A channel commits its new level only after DEBOUNCE_LIMIT consecutive
    // differing synced samples; any sample matching the current level restarts it.
    always_comb begin
        level_d  = o_Sw_Level;
        rise_d   = '0;
        fall_d   = '0;
        toggle_d = o_LED_Toggle;
        for (int n = 0; n < NUM_SW; n++) begin
            count_d[n] = '0;
            if (sync[n] != o_Sw_Level[n]) begin
                if (count_q[n] == CNT_LAST) begin
                    level_d[n]  = sync[n];
                    rise_d[n]   = sync[n];
                    fall_d[n]   = ~sync[n];
                    toggle_d[n] = o_LED_Toggle[n] ^ ~sync[n];
                end else begin
                    count_d[n] = count_q[n] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int n = 0; n < NUM_SW; n++) begin
                count_q[n] <= '0;
            end
            o_Sw_Level   <= '0;
            o_Sw_Rise    <= '0;
            o_Sw_Fall    <= '0;
            o_LED_Toggle <= '0;
        end else begin
            sync_q[0] <= i_Switch;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            for (int n = 0; n < NUM_SW; n++) begin
                count_q[n] <= count_d[n];
            end
            o_Sw_Level   <= level_d;
            o_Sw_Rise    <= rise_d;
            o_Sw_Fall    <= fall_d;
            o_LED_Toggle <= toggle_d;
        end
    end

endmodule
